muldiv_unit: RTL

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative 32x32 multiply / 32/32 divide, signed and unsigned.
// One multiplier bit or quotient bit per CALC cycle. Results land on entry to FIN.
module muldiv_unit (
  input  logic        CLK,
  input  logic        RST,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] Port_A,
  input  logic [31:0] Port_B,
  output logic        busy,
  output logic        done,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        div_by_zero
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIN} state_t;

  state_t      r_state, w_state_nx;
  logic [4:0]  r_cnt;
  logic        r_is_div, r_neg_res, r_neg_rem, r_bzero;
  logic [63:0] r_mcand;   // multiply: shifting multiplicand; divide: raw dividend in [31:0]
  logic [31:0] r_bv;      // multiply: shifting multiplier; divide: divisor magnitude
  logic [63:0] r_acc;     // product accumulator
  logic [31:0] r_rem;     // remainder (always < divisor, so 32 bits hold it between steps)
  logic [31:0] r_quo;     // dividend bits shift out the top, quotient bits shift in

  logic        w_signed, w_a_neg, w_b_neg;
  logic [31:0] w_a_mag, w_b_mag;
  logic [63:0] w_acc_nx, w_prod;
  logic [32:0] w_shift, w_diff;
  logic        w_ge;
  logic [31:0] w_rem_nx, w_quo_nx, w_q, w_r;

  // Operand magnitudes at acceptance; 0x80000000 becomes unsigned 2^31.
  always_comb begin
    w_signed = ~op[0];
    w_a_neg  = w_signed & Port_A[31];
    w_b_neg  = w_signed & Port_B[31];
    w_a_mag  = w_a_neg ? (~Port_A + 32'd1) : Port_A;
    w_b_mag  = w_b_neg ? (~Port_B + 32'd1) : Port_B;
  end

  // One shift-add / restoring-divide step plus sign fix-up of the final step.
  always_comb begin
    w_acc_nx = r_bv[0] ? (r_acc + r_mcand) : r_acc;
    w_shift  = {r_rem, r_quo[31]};
    w_diff   = w_shift - {1'b0, r_bv};
    w_ge     = ~w_diff[32];
    w_rem_nx = w_ge ? w_diff[31:0] : w_shift[31:0];
    w_quo_nx = {r_quo[30:0], w_ge};
    w_prod   = r_neg_res ? (~w_acc_nx + 64'd1) : w_acc_nx;
    w_q      = r_neg_res ? (~w_quo_nx + 32'd1) : w_quo_nx;
    w_r      = r_neg_rem ? (~w_rem_nx + 32'd1) : w_rem_nx;
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_state_nx;
  end

  // Next-state and status outputs.
  always_comb begin
    w_state_nx = r_state;
    busy       = 1'b0;
    done       = 1'b0;
    case (r_state)
      S_IDLE: if (start) w_state_nx = S_CALC;
      S_CALC: begin
        busy = 1'b1;
        if (r_cnt == 5'd31) w_state_nx = S_FIN;
      end
      S_FIN: begin
        busy       = 1'b1;
        done       = 1'b1;
        w_state_nx = S_IDLE;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  // Operand capture, iteration datapath and result registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_cnt       <= '0;
      r_is_div    <= 1'b0;
      r_neg_res   <= 1'b0;
      r_neg_rem   <= 1'b0;
      r_bzero     <= 1'b0;
      r_mcand     <= '0;
      r_bv        <= '0;
      r_acc       <= '0;
      r_rem       <= '0;
      r_quo       <= '0;
      HI          <= '0;
      LO          <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (start) begin
            r_is_div  <= op[1];
            r_neg_res <= w_a_neg ^ w_b_neg;
            r_neg_rem <= w_a_neg;
            r_bzero   <= (Port_B == 32'd0);
            r_mcand   <= op[1] ? {32'd0, Port_A} : {32'd0, w_a_mag};
            r_bv      <= w_b_mag;
            r_acc     <= '0;
            r_rem     <= '0;
            r_quo     <= w_a_mag;
          end
        end
        S_CALC: begin
          r_cnt <= r_cnt + 5'd1;
          if (r_is_div) begin
            r_rem <= w_rem_nx;
            r_quo <= w_quo_nx;
          end else begin
            r_acc   <= w_acc_nx;
            r_mcand <= r_mcand << 1;
            r_bv    <= r_bv >> 1;
          end
          // Results are taken from the last step's combinational value so they
          // are already valid in the FIN cycle alongside done.
          if (r_cnt == 5'd31) begin
            if (r_is_div && r_bzero) begin
              LO          <= '1;
              HI          <= r_mcand[31:0];
              div_by_zero <= 1'b1;
            end else if (r_is_div) begin
              LO          <= w_q;
              HI          <= w_r;
              div_by_zero <= 1'b0;
            end else begin
              LO          <= w_prod[31:0];
              HI          <= w_prod[63:32];
              div_by_zero <= 1'b0;
            end
          end
        end
        default: r_cnt <= '0;
      endcase
    end
  end

endmodule
